// File: rtl/full_adder.sv
// Single-bit full adder with a registered stage and LSB-first bit-serial chaining.
// The stored carry feeds the next accepted serial bit unless a new word starts.
module full_adder #(
    parameter int WORD_BITS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic in_valid,
    input  logic serial_en,
    input  logic first,
    output logic sum,
    output logic carry,
    output logic sum_q,
    output logic carry_q,
    output logic out_valid,
    output logic word_done,
    output logic word_carry
);

    localparam int CW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORD_BITS - 1);

    logic          r_carry_state;
    logic [CW-1:0] r_bit_cnt;
    logic          r_sum_q;
    logic          r_carry_q;
    logic          r_out_valid;
    logic          r_word_done;
    logic          r_word_carry;

    logic w_chain;
    logic w_cin_eff;
    logic w_sum;
    logic w_carry;
    logic w_accept;

    // Reset forces the chained carry to zero without waiting for a clock.
    assign w_chain   = serial_en & ~first;
    assign w_cin_eff = w_chain ? (r_carry_state & ~rst) : cin;
    assign w_sum     = a ^ b ^ w_cin_eff;
    assign w_carry   = (a & b) | (a & w_cin_eff) | (b & w_cin_eff);
    assign w_accept  = in_valid & serial_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum_q     <= 1'b0;
            r_carry_q   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum_q   <= w_sum;
                r_carry_q <= w_carry;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carry_state <= 1'b0;
            r_bit_cnt     <= '0;
            r_word_done   <= 1'b0;
            r_word_carry  <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            if (w_accept) begin
                if (first) begin
                    r_bit_cnt     <= CW'(1);
                    r_carry_state <= w_carry;
                end else if (r_bit_cnt == LAST) begin
                    r_bit_cnt     <= '0;
                    r_carry_state <= 1'b0;
                    r_word_carry  <= w_carry;
                    r_word_done   <= 1'b1;
                end else begin
                    r_bit_cnt     <= r_bit_cnt + CW'(1);
                    r_carry_state <= w_carry;
                end
            end
        end
    end

    assign sum        = w_sum;
    assign carry      = w_carry;
    assign sum_q      = r_sum_q;
    assign carry_q    = r_carry_q;
    assign out_valid  = r_out_valid;
    assign word_done  = r_word_done;
    assign word_carry = r_word_carry;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: reference model plus queued registered results.
// Serial words are reassembled from sum_q and compared to fixed sums.
module tb_full_adder;

    localparam int WB = 8;

    logic clk;
    logic rst;
    logic a, b, cin, in_valid, serial_en, first;
    logic sum, carry, sum_q, carry_q, out_valid, word_done, word_carry;

    full_adder #(.WORD_BITS(WB)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .serial_en (serial_en),
        .first     (first),
        .sum       (sum),
        .carry     (carry),
        .sum_q     (sum_q),
        .carry_q   (carry_q),
        .out_valid (out_valid),
        .word_done (word_done),
        .word_carry(word_carry)
    );

    typedef struct packed {
        logic c;
        logic s;
    } res_t;

    res_t sb[$];

    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    logic m_cs = 1'b0;
    int   m_cnt = 0;
    logic m_wc = 1'b0;
    logic m_sq = 1'b0;
    logic m_cq = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic beat(input logic ia, input logic ib, input logic ic,
                        input logic iv, input logic is, input logic ifst);
        logic ce, es, ec, ewd;
        res_t r;
        @(negedge clk);
        a = ia; b = ib; cin = ic;
        in_valid = iv; serial_en = is; first = ifst;
        ce = (is && !ifst) ? m_cs : ic;
        es = ia ^ ib ^ ce;
        ec = (ia & ib) | (ia & ce) | (ib & ce);
        #1;
        chk("sum", 8'(sum), 8'(es));
        chk("carry", 8'(carry), 8'(ec));
        if (iv) sb.push_back('{c: ec, s: es});
        ewd = 1'b0;
        if (iv && is) begin
            if (ifst) begin
                m_cnt = 1; m_cs = ec;
            end else if (m_cnt == WB - 1) begin
                m_cnt = 0; m_cs = 1'b0; m_wc = ec; ewd = 1'b1;
            end else begin
                m_cnt++; m_cs = ec;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 8'(out_valid), 8'(iv));
        if (iv && sb.size() > 0) begin
            r = sb.pop_front();
            m_sq = r.s; m_cq = r.c;
            chk("sum_q", 8'(sum_q), 8'(r.s));
            chk("carry_q", 8'(carry_q), 8'(r.c));
        end else if (!iv) begin
            chk("sum_q_hold", 8'(sum_q), 8'(m_sq));
            chk("carry_q_hold", 8'(carry_q), 8'(m_cq));
        end
        chk("word_done", 8'(word_done), 8'(ewd));
        chk("word_carry", 8'(word_carry), 8'(m_wc));
        if (word_done) done_cnt++;
    endtask

    task automatic serial_word(input logic [7:0] wa, input logic [7:0] wb,
                               input logic wcin, input logic use_first,
                               input int gap_after, input int mix_after,
                               input logic [7:0] exp_s, input logic exp_wc);
        logic [7:0] res;
        int d0;
        d0 = done_cnt;
        res = '0;
        for (int i = 0; i < WB; i++) begin
            beat(wa[i], wb[i], (i == 0) ? wcin : 1'b0, 1'b1, 1'b1,
                 use_first && (i == 0));
            res[i] = sum_q;
            if (i == gap_after)
                repeat (3) beat(1'($urandom), 1'($urandom), 1'($urandom),
                                1'b0, 1'b1, 1'b0);
            if (i == mix_after) beat(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        chk("word_sum", res, exp_s);
        chk("word_carry_final", 8'(word_carry), 8'(exp_wc));
        chk("done_pulses", 8'(done_cnt - d0), 8'd1);
    endtask

    logic [7:0] tt;
    logic [7:0] ffa, ffb;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tt = 8'b0;
        rst = 1'b1;
        a = 0; b = 0; cin = 0; in_valid = 0; serial_en = 0; first = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum_q", 8'(sum_q), 8'd0);
        chk("rst_carry_q", 8'(carry_q), 8'd0);
        chk("rst_out_valid", 8'(out_valid), 8'd0);
        chk("rst_word_done", 8'(word_done), 8'd0);
        chk("rst_word_carry", 8'(word_carry), 8'd0);
        rst = 1'b0;

        // Truth table, {carry,sum}: 00 01 01 10 01 10 10 11
        for (int i = 0; i < 8; i++) begin
            tt = 8'(i);
            beat(tt[2], tt[1], tt[0], 1'b1, 1'b0, 1'b0);
            case (i)
                0:       chk("tt", 8'({carry, sum}), 8'd0);
                1, 2, 4: chk("tt", 8'({carry, sum}), 8'd1);
                3, 5, 6: chk("tt", 8'({carry, sum}), 8'd2);
                default: chk("tt", 8'({carry, sum}), 8'd3);
            endcase
        end

        beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("reg_sum_q", 8'(sum_q), 8'd1);
        chk("reg_carry_q", 8'(carry_q), 8'd1);
        beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reg_ovld_drop", 8'(out_valid), 8'd0);
        chk("reg_sum_q_hold", 8'(sum_q), 8'd1);

        serial_word(8'hFF, 8'h01, 1'b0, 1'b1, -1, -1, 8'h00, 1'b1);

        // Partial FF+FF word, then async reset mid-cycle
        ffa = 8'hFF; ffb = 8'hFF;
        for (int i = 0; i < 5; i++)
            beat(ffa[i], ffb[i], 1'b0, 1'b1, 1'b1, i == 0);
        #2;
        a = 1'b0; b = 1'b1; cin = 1'b0;
        in_valid = 1'b0; serial_en = 1'b1; first = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst_sum_q", 8'(sum_q), 8'd0);
        chk("mrst_carry_q", 8'(carry_q), 8'd0);
        chk("mrst_out_valid", 8'(out_valid), 8'd0);
        chk("mrst_word_done", 8'(word_done), 8'd0);
        chk("mrst_word_carry", 8'(word_carry), 8'd0);
        chk("mrst_sum_chain0", 8'({carry, sum}), 8'd1);
        m_cs = 1'b0; m_cnt = 0; m_wc = 1'b0; m_sq = 1'b0; m_cq = 1'b0;
        sb.delete();
        #1;
        rst = 1'b0;

        serial_word(8'h01, 8'h01, 1'b1, 1'b0, -1, -1, 8'h02, 1'b0);
        serial_word(8'h35, 8'h4A, 1'b1, 1'b1, 3, -1, 8'h80, 1'b0);
        serial_word(8'hFF, 8'h01, 1'b0, 1'b1, -1, 2, 8'h00, 1'b1);

        // Aborted word: three bits, then a fresh word restarts with first
        ffa = 8'hFF;
        for (int i = 0; i < 3; i++)
            beat(ffa[i], ffa[i], 1'b0, 1'b1, 1'b1, i == 0);
        serial_word(8'h35, 8'h4A, 1'b1, 1'b1, -1, -1, 8'h80, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
